// File: rtl/user_stream_adapter_if.sv
// Stream bundle between the PCIe DMA engine, the adapter and the user core.
interface user_stream_adapter_if #(
  parameter int unsigned NUM_STR    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_STR-1:0]            i_pcie_str_data_valid;
  logic [NUM_STR-1:0]            o_pcie_str_ack;
  logic [NUM_STR*DATA_WIDTH-1:0] i_pcie_str_data;
  logic [NUM_STR-1:0]            o_pcie_str_data_valid;
  logic [NUM_STR-1:0]            i_pcie_str_ack;
  logic [NUM_STR*DATA_WIDTH-1:0] o_pcie_str_data;
  logic [NUM_STR-1:0]            i_adpt_str_data_valid;
  logic [NUM_STR-1:0]            o_adpt_str_ack;
  logic [NUM_STR*DATA_WIDTH-1:0] i_adpt_str_data;
  logic [NUM_STR-1:0]            o_adpt_str_data_valid;
  logic [NUM_STR-1:0]            i_adpt_str_ack;
  logic [NUM_STR*DATA_WIDTH-1:0] o_adpt_str_data;
  logic [NUM_STR-1:0]            i_flush;
  logic [NUM_STR*LW-1:0]         o_wr_level;
  logic [NUM_STR*LW-1:0]         o_rd_level;
  logic [NUM_STR-1:0]            o_wr_afull;
  logic [NUM_STR-1:0]            o_rd_afull;

  // Adapter side
  modport slave (
    input  i_pcie_str_data_valid, i_pcie_str_data, i_pcie_str_ack,
    input  i_adpt_str_data_valid, i_adpt_str_data, i_adpt_str_ack, i_flush,
    output o_pcie_str_ack, o_pcie_str_data_valid, o_pcie_str_data,
    output o_adpt_str_ack, o_adpt_str_data_valid, o_adpt_str_data,
    output o_wr_level, o_rd_level, o_wr_afull, o_rd_afull
  );

  // Environment side (DMA engine plus user core)
  modport master (
    output i_pcie_str_data_valid, i_pcie_str_data, i_pcie_str_ack,
    output i_adpt_str_data_valid, i_adpt_str_data, i_adpt_str_ack, i_flush,
    input  o_pcie_str_ack, o_pcie_str_data_valid, o_pcie_str_data,
    input  o_adpt_str_ack, o_adpt_str_data_valid, o_adpt_str_data,
    input  o_wr_level, o_rd_level, o_wr_afull, o_rd_afull
  );
endinterface

// File: rtl/user_stream_adapter.sv
// Per-channel host->user (wr) and user->host (rd) FWFT FIFOs with flush,
// occupancy levels and almost-full flags. FIFO index f < NUM_STR is the wr
// FIFO of channel f; f >= NUM_STR is the rd FIFO of channel f-NUM_STR.
module user_stream_adapter #(
  parameter int unsigned NUM_STR    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_THRESH  = 12
) (
  input logic                  i_user_clk,
  input logic                  i_rst,
  user_stream_adapter_if.slave bus
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PW = LW - 1;
  localparam int unsigned NF = 2 * NUM_STR;

  logic [NF-1:0]         push_valid;
  logic [NF-1:0]         pop_ack;
  logic [NF-1:0]         flush;
  logic [DATA_WIDTH-1:0] push_data [NF];
  logic [NF-1:0]         ack_v;
  logic [NF-1:0]         valid_v;
  logic [NF-1:0]         afull_v;
  logic [LW-1:0]         level_v [NF];
  logic [DATA_WIDTH-1:0] dout_v  [NF];

  // Map the two directions of each channel onto the flat FIFO index space
  for (genvar ch = 0; ch < NUM_STR; ch++) begin : g_ch
    assign push_valid[ch]         = bus.i_pcie_str_data_valid[ch];
    assign push_data[ch]          = bus.i_pcie_str_data[ch*DATA_WIDTH +: DATA_WIDTH];
    assign pop_ack[ch]            = bus.i_adpt_str_ack[ch];
    assign flush[ch]              = bus.i_flush[ch];
    assign push_valid[NUM_STR+ch] = bus.i_adpt_str_data_valid[ch];
    assign push_data[NUM_STR+ch]  = bus.i_adpt_str_data[ch*DATA_WIDTH +: DATA_WIDTH];
    assign pop_ack[NUM_STR+ch]    = bus.i_pcie_str_ack[ch];
    assign flush[NUM_STR+ch]      = bus.i_flush[ch];

    assign bus.o_pcie_str_ack[ch]                                = ack_v[ch];
    assign bus.o_adpt_str_data_valid[ch]                         = valid_v[ch];
    assign bus.o_adpt_str_data[ch*DATA_WIDTH +: DATA_WIDTH]      = dout_v[ch];
    assign bus.o_wr_level[ch*LW +: LW]                           = level_v[ch];
    assign bus.o_wr_afull[ch]                                    = afull_v[ch];
    assign bus.o_adpt_str_ack[ch]                                = ack_v[NUM_STR+ch];
    assign bus.o_pcie_str_data_valid[ch]                         = valid_v[NUM_STR+ch];
    assign bus.o_pcie_str_data[ch*DATA_WIDTH +: DATA_WIDTH]      = dout_v[NUM_STR+ch];
    assign bus.o_rd_level[ch*LW +: LW]                           = level_v[NUM_STR+ch];
    assign bus.o_rd_afull[ch]                                    = afull_v[NUM_STR+ch];
  end

  for (genvar f = 0; f < NF; f++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         wr_ptr_n;
    logic [PW-1:0]         rd_ptr_n;
    logic [LW-1:0]         level_q;
    logic [LW-1:0]         level_n;
    logic                  valid_q;
    logic                  ack_q;
    logic                  afull_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] head_n;
    logic                  push;
    logic                  pop;

    // Next pointers/level; flush wins over any push or pop in the same cycle
    always_comb begin
      push     = push_valid[f] & ack_q & ~flush[f];
      pop      = valid_q & pop_ack[f] & ~flush[f];
      wr_ptr_n = wr_ptr_q;
      rd_ptr_n = rd_ptr_q;
      level_n  = level_q;
      if (flush[f]) begin
        wr_ptr_n = '0;
        rd_ptr_n = '0;
        level_n  = '0;
      end else begin
        if (push) wr_ptr_n = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_n = rd_ptr_q + PW'(1);
        level_n = level_q + LW'(push) - LW'(pop);
      end
      // A word written this cycle into an otherwise empty FIFO bypasses the array
      head_n = (push && (rd_ptr_n == wr_ptr_q)) ? push_data[f] : mem[rd_ptr_n];
    end

    // Storage array, no reset
    always_ff @(posedge i_user_clk) begin
      if (push) mem[wr_ptr_q] <= push_data[f];
    end

    // Pointers, level and registered status/head outputs
    always_ff @(posedge i_user_clk or negedge i_rst) begin
      if (!i_rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        valid_q  <= 1'b0;
        ack_q    <= 1'b0;
        afull_q  <= 1'b0;
        dout_q   <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_n;
        rd_ptr_q <= rd_ptr_n;
        level_q  <= level_n;
        valid_q  <= (level_n != '0);
        ack_q    <= (level_n < LW'(FIFO_DEPTH));
        afull_q  <= (level_n >= LW'(AF_THRESH));
        if (level_n != '0) dout_q <= head_n;
      end
    end

    assign ack_v[f]   = ack_q;
    assign valid_v[f] = valid_q;
    assign afull_v[f] = afull_q;
    assign level_v[f] = level_q;
    assign dout_v[f]  = dout_q;
  end

endmodule

// File: tb/tb_user_stream_adapter.sv
// Scoreboard bench: per-FIFO queues model the adapter; a negedge monitor
// compares status and head data, then applies the transfers of the next edge.
module tb_user_stream_adapter;
  localparam int NS = 4;
  localparam int DW = 64;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int LW = $clog2(D) + 1;
  localparam int NF = 2 * NS;

  logic clk;
  logic rst_n;
  logic armed;
  int   n_cmp;
  int   n_err;
  logic [DW-1:0] q [NF][$];

  user_stream_adapter_if #(.NUM_STR(NS), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) bus ();

  user_stream_adapter #(
    .NUM_STR(NS), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .AF_THRESH(AF)
  ) dut (
    .i_user_clk(clk),
    .i_rst     (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ready is expected only once a clock edge has been seen out of reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  task automatic chk(input string nm, input int f, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s fifo%0d at %0t: got %0h expected %0h", nm, f, $time, act, exp);
    end
  endtask

  // Monitor: compare against model, then update model with the upcoming edge's transfers
  always @(negedge clk) begin
    for (int f = 0; f < NF; f++) begin
      automatic int ch = f % NS;
      automatic logic in_v, acc, ov, pa, af, fl;
      automatic logic [DW-1:0] id, od;
      automatic logic [LW-1:0] lv;
      automatic int sz;
      if (f < NS) begin
        in_v = bus.i_pcie_str_data_valid[ch];
        id   = bus.i_pcie_str_data[ch*DW +: DW];
        acc  = bus.o_pcie_str_ack[ch];
        ov   = bus.o_adpt_str_data_valid[ch];
        od   = bus.o_adpt_str_data[ch*DW +: DW];
        pa   = bus.i_adpt_str_ack[ch];
        lv   = bus.o_wr_level[ch*LW +: LW];
        af   = bus.o_wr_afull[ch];
      end else begin
        in_v = bus.i_adpt_str_data_valid[ch];
        id   = bus.i_adpt_str_data[ch*DW +: DW];
        acc  = bus.o_adpt_str_ack[ch];
        ov   = bus.o_pcie_str_data_valid[ch];
        od   = bus.o_pcie_str_data[ch*DW +: DW];
        pa   = bus.i_pcie_str_ack[ch];
        lv   = bus.o_rd_level[ch*LW +: LW];
        af   = bus.o_rd_afull[ch];
      end
      fl = bus.i_flush[ch];
      sz = q[f].size();
      if (!rst_n) begin
        chk("rst_valid", f, DW'(ov), '0);
        chk("rst_ack",   f, DW'(acc), '0);
        chk("rst_level", f, DW'(lv), '0);
        chk("rst_afull", f, DW'(af), '0);
        chk("rst_data",  f, od, '0);
        q[f].delete();
      end else begin
        chk("level", f, DW'(lv),  DW'(sz));
        chk("valid", f, DW'(ov),  DW'(sz != 0));
        chk("ack",   f, DW'(acc), DW'(armed && (sz < D)));
        chk("afull", f, DW'(af),  DW'(sz >= AF));
        if (ov && sz != 0) chk("data", f, od, q[f][0]);
        if (fl) q[f].delete();
        else begin
          if (ov && pa && sz != 0) void'(q[f].pop_front());
          if (in_v && acc) q[f].push_back(id);
        end
      end
    end
  end

  task automatic idle();
    bus.i_pcie_str_data_valid = '0;
    bus.i_pcie_str_ack        = '0;
    bus.i_adpt_str_data_valid = '0;
    bus.i_adpt_str_ack        = '0;
    bus.i_flush               = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Push n sequential words base.. into wr (dir=0) or rd (dir=1) FIFO of ch
  task automatic push_n(input bit dir, input int ch, input int n, input int base);
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    while (sent < n && guard < 4 * n + 8) begin
      if (!dir) begin
        bus.i_pcie_str_data_valid[ch]      = 1'b1;
        bus.i_pcie_str_data[ch*DW +: DW]   = DW'(base + sent);
      end else begin
        bus.i_adpt_str_data_valid[ch]      = 1'b1;
        bus.i_adpt_str_data[ch*DW +: DW]   = DW'(base + sent);
      end
      @(negedge clk);
      if (!dir ? bus.o_pcie_str_ack[ch] : bus.o_adpt_str_ack[ch]) sent++;
      next_cycle();
      guard++;
    end
    if (!dir) bus.i_pcie_str_data_valid[ch] = 1'b0;
    else      bus.i_adpt_str_data_valid[ch] = 1'b0;
    chk("push_count", ch, DW'(sent), DW'(n));
  endtask

  // Pop until the FIFO reports empty; returns at a negedge with ack released
  task automatic drain(input bit dir, input int ch);
    int guard;
    logic [LW-1:0] lv;
    guard = 0;
    if (!dir) bus.i_adpt_str_ack[ch] = 1'b1;
    else      bus.i_pcie_str_ack[ch] = 1'b1;
    lv = '1;
    while (guard < 4 * D + 8) begin
      @(negedge clk);
      lv = !dir ? bus.o_wr_level[ch*LW +: LW] : bus.o_rd_level[ch*LW +: LW];
      if (lv == '0) break;
      next_cycle();
      guard++;
    end
    if (!dir) bus.i_adpt_str_ack[ch] = 1'b0;
    else      bus.i_pcie_str_ack[ch] = 1'b0;
    chk("drain_level", ch, DW'(lv), '0);
  endtask

  initial begin
    logic [NS*DW-1:0] dv;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    bus.i_pcie_str_data = '0;
    bus.i_adpt_str_data = '0;

    // Reset held with traffic present
    bus.i_pcie_str_data_valid = '1;
    bus.i_adpt_str_data_valid = '1;
    bus.i_pcie_str_ack        = '1;
    bus.i_adpt_str_ack        = '1;
    repeat (4) next_cycle();
    idle();
    rst_n = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("ack_after_rst_wr", 0, DW'(bus.o_pcie_str_ack), DW'({NS{1'b1}}));
    chk("ack_after_rst_rd", 0, DW'(bus.o_adpt_str_ack), DW'({NS{1'b1}}));
    next_cycle();

    // Ch0 wr: fill to full with sink stalled, then drain in order
    push_n(1'b0, 0, D, 1);
    @(negedge clk);
    chk("full_level", 0, DW'(bus.o_wr_level[0 +: LW]), DW'(D));
    chk("full_ack",   0, DW'(bus.o_pcie_str_ack[0]), '0);
    chk("full_afull", 0, DW'(bus.o_wr_afull[0]), DW'(1));
    next_cycle();
    bus.i_pcie_str_data_valid[0] = 1'b1;
    bus.i_pcie_str_data[0 +: DW] = DW'(64'hdead);
    repeat (2) next_cycle();
    bus.i_pcie_str_data_valid[0] = 1'b0;
    drain(1'b0, 0);
    chk("empty_valid", 0, DW'(bus.o_adpt_str_data_valid[0]), '0);
    chk("empty_hold",  0, bus.o_adpt_str_data[0 +: DW], DW'(D));
    next_cycle();

    // Ch2 rd: full with simultaneous push and pop
    push_n(1'b1, 2, D, 'h500);
    bus.i_adpt_str_data_valid[2]  = 1'b1;
    bus.i_adpt_str_data[2*DW +: DW] = DW'(64'h77);
    bus.i_pcie_str_ack[2]         = 1'b1;
    next_cycle();
    bus.i_adpt_str_data_valid[2]  = 1'b0;
    bus.i_pcie_str_ack[2]         = 1'b0;
    @(negedge clk);
    chk("simul_level", NS + 2, DW'(bus.o_rd_level[2*LW +: LW]), DW'(D - 1));
    chk("simul_ack",   NS + 2, DW'(bus.o_adpt_str_ack[2]), DW'(1));
    drain(1'b1, 2);
    next_cycle();

    // Flush ch1 with concurrent pushes; other channels keep their state
    push_n(1'b0, 1, 5, 'h100);
    push_n(1'b0, 0, 3, 'h200);
    push_n(1'b1, 3, 2, 'h300);
    bus.i_flush                     = NS'(2);
    bus.i_pcie_str_data_valid[1]    = 1'b1;
    bus.i_pcie_str_data[1*DW +: DW] = DW'(64'h999);
    bus.i_adpt_str_data_valid[1]    = 1'b1;
    bus.i_adpt_str_data[1*DW +: DW] = DW'(64'h888);
    next_cycle();
    idle();
    @(negedge clk);
    chk("flush_wr_level", 1, DW'(bus.o_wr_level[1*LW +: LW]), '0);
    chk("flush_rd_level", NS + 1, DW'(bus.o_rd_level[1*LW +: LW]), '0);
    chk("flush_valid",    1, DW'(bus.o_adpt_str_data_valid[1]), '0);
    chk("other_level0",   0, DW'(bus.o_wr_level[0 +: LW]), DW'(3));
    chk("other_level3",   NS + 3, DW'(bus.o_rd_level[3*LW +: LW]), DW'(2));
    chk("other_data0",    0, bus.o_adpt_str_data[0 +: DW], DW'(64'h200));
    next_cycle();
    bus.i_adpt_str_ack = '1;
    bus.i_pcie_str_ack = '1;
    repeat (2 * D) next_cycle();
    idle();

    // Random traffic on every port, occasional flush, one mid-run reset
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bus.i_pcie_str_data_valid = NS'($urandom);
      bus.i_adpt_str_data_valid = NS'($urandom);
      bus.i_pcie_str_ack        = NS'($urandom);
      bus.i_adpt_str_ack        = NS'($urandom);
      for (int c = 0; c < NS; c++) begin
        bus.i_flush[c] = ($urandom_range(0, 63) == 0);
        dv[c*DW +: DW] = DW'({$urandom(), $urandom()});
      end
      bus.i_pcie_str_data = dv;
      for (int c = 0; c < NS; c++) dv[c*DW +: DW] = DW'({$urandom(), $urandom()});
      bus.i_adpt_str_data = dv;
      if (cyc == 5000) rst_n = 1'b0;
      if (cyc == 5003) rst_n = 1'b1;
      next_cycle();
    end
    idle();
    repeat (4) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
